// File: rtl/pin_entry_transmitter_if.sv
`default_nettype none
// ============================================================================
//  Module      : pin_entry_transmitter_if
//  Description : Host/controller-side signal bundle of the PIN entry link.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pin_entry_transmitter_if;
    logic        START;
    logic [15:0] PIN;
    logic        ACCESO_ACEPTADO;
    logic        ACCESO_DENEGADO;
    logic        SOLICITUD_ACCESO;
    logic [3:0]  DIGITO;
    logic        DIGITO_STB;
    logic        BUSY;
    logic        DONE;
    logic [1:0]  RESULT;

    modport master (
        output START, PIN, ACCESO_ACEPTADO, ACCESO_DENEGADO,
        input  SOLICITUD_ACCESO, DIGITO, DIGITO_STB, BUSY, DONE, RESULT
    );

    modport slave (
        input  START, PIN, ACCESO_ACEPTADO, ACCESO_DENEGADO,
        output SOLICITUD_ACCESO, DIGITO, DIGITO_STB, BUSY, DONE, RESULT
    );
endinterface
`default_nettype wire

// File: rtl/pin_entry_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : pin_entry_transmitter
//  Description : Sends a latched 16-bit PIN as four strobed nibbles, then
//                waits for an accept/deny verdict or a timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module pin_entry_transmitter #(
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 16
) (
    input  wire logic             CLK,
    input  wire logic             RESET,
    pin_entry_transmitter_if.slave bus
);

    localparam int c_gap_w = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int c_tmo_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_CYCLES - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQUEST   = 3'd1,
        SEND      = 3'd2,
        GAP       = 3'd3,
        WAIT_RESP = 3'd4,
        REPORT    = 3'd5
    } state_t;

    state_t               state_q,  state_d;
    logic [15:0]          shift_q,  shift_d;
    logic [1:0]           idx_q,    idx_d;
    logic [c_gap_w-1:0]   gap_q,    gap_d;
    logic [c_tmo_w-1:0]   tmo_q,    tmo_d;
    logic                 sol_q,    sol_d;
    logic [3:0]           digito_q, digito_d;
    logic                 stb_q,    stb_d;
    logic                 busy_q,   busy_d;
    logic                 done_q,   done_d;
    logic [1:0]           result_q, result_d;
    logic                 emit;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        tmo_d    = tmo_q;
        sol_d    = 1'b0;
        stb_d    = 1'b0;
        done_d   = 1'b0;
        digito_d = digito_q;
        result_d = result_q;
        emit     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    shift_d  = bus.PIN;
                    idx_d    = 2'd0;
                    gap_d    = '0;
                    tmo_d    = '0;
                    sol_d    = 1'b1;
                    result_d = 2'b00;
                    state_d  = REQUEST;
                end
            end
            REQUEST: begin
                idx_d   = 2'd0;
                emit    = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (idx_q == 2'd3) begin
                    tmo_d   = '0;
                    state_d = WAIT_RESP;
                end else if (GAP_CYCLES == 0) begin
                    idx_d = idx_q + 2'd1;
                    emit  = 1'b1;
                end else begin
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == c_gap_last) begin
                    idx_d   = idx_q + 2'd1;
                    emit    = 1'b1;
                    state_d = SEND;
                end else begin
                    gap_d = gap_q + c_gap_w'(1);
                end
            end
            WAIT_RESP: begin
                // Deny wins when both verdicts arrive together (fail-safe).
                if (bus.ACCESO_DENEGADO) begin
                    result_d = 2'b10;
                    done_d   = 1'b1;
                    state_d  = REPORT;
                end else if (bus.ACCESO_ACEPTADO) begin
                    result_d = 2'b01;
                    done_d   = 1'b1;
                    state_d  = REPORT;
                end else if (tmo_q == c_tmo_last) begin
                    result_d = 2'b11;
                    done_d   = 1'b1;
                    state_d  = REPORT;
                end else begin
                    tmo_d = tmo_q + c_tmo_w'(1);
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                shift_d  = '0;
                idx_d    = 2'd0;
                gap_d    = '0;
                tmo_d    = '0;
                digito_d = 4'h0;
                result_d = 2'b00;
            end
        endcase

        // Digits leave MSB-first; the shifter is consumed one nibble per strobe.
        if (emit) begin
            digito_d = shift_q[15:12];
            shift_d  = {shift_q[11:0], 4'h0};
            stb_d    = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= 2'd0;
            gap_q    <= '0;
            tmo_q    <= '0;
            sol_q    <= 1'b0;
            digito_q <= 4'h0;
            stb_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            tmo_q    <= tmo_d;
            sol_q    <= sol_d;
            digito_q <= digito_d;
            stb_q    <= stb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign bus.SOLICITUD_ACCESO = sol_q;
    assign bus.DIGITO           = digito_q;
    assign bus.DIGITO_STB       = stb_q;
    assign bus.BUSY             = busy_q;
    assign bus.DONE             = done_q;
    assign bus.RESULT           = result_q;

endmodule
`default_nettype wire

// File: tb/tb_pin_entry_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pin_entry_transmitter
//  Description : Directed scenarios for pin_entry_transmitter (gap 2 and gap 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pin_entry_transmitter;

    logic        CLK = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] pin;
    logic        acc;
    logic        den;
    logic        sel;
    int          errors = 0;
    int          checks = 0;

    always #5 CLK = ~CLK;

    pin_entry_transmitter_if ifa ();
    pin_entry_transmitter_if ifb ();

    assign ifa.START = start;  assign ifb.START = start;
    assign ifa.PIN   = pin;    assign ifb.PIN   = pin;
    assign ifa.ACCESO_ACEPTADO = acc;  assign ifb.ACCESO_ACEPTADO = acc;
    assign ifa.ACCESO_DENEGADO = den;  assign ifb.ACCESO_DENEGADO = den;

    pin_entry_transmitter #(.GAP_CYCLES(2), .TIMEOUT(16)) dut_a (.CLK(CLK), .RESET(rst), .bus(ifa));
    pin_entry_transmitter #(.GAP_CYCLES(0), .TIMEOUT(16)) dut_b (.CLK(CLK), .RESET(rst), .bus(ifb));

    wire       w_sol  = sel ? ifb.SOLICITUD_ACCESO : ifa.SOLICITUD_ACCESO;
    wire       w_stb  = sel ? ifb.DIGITO_STB : ifa.DIGITO_STB;
    wire [3:0] w_dig  = sel ? ifb.DIGITO : ifa.DIGITO;
    wire       w_busy = sel ? ifb.BUSY : ifa.BUSY;
    wire       w_done = sel ? ifb.DONE : ifa.DONE;
    wire [1:0] w_res  = sel ? ifb.RESULT : ifa.RESULT;

    // Per-transfer observations, filled by xfer and judged by each test.
    int          req_cnt, req_last, stb_cnt, done_cnt, done_cyc, busy_low;
    int          stb_cyc [8];
    logic [3:0]  dig [8];
    logic [1:0]  res_at_req, res_done, res_end;
    logic        overlap, zero_after_rst;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic xfer(input logic [15:0] p, input logic [15:0] p2,
                        input int s1, input int s2, input int a1, input int a2,
                        input int d1, input int r1, input int ncyc);
        req_cnt = 0; req_last = -1; stb_cnt = 0; done_cnt = 0; done_cyc = -1;
        busy_low = -1; overlap = 1'b0; zero_after_rst = 1'b0;
        res_at_req = 2'bxx; res_done = 2'bxx; res_end = 2'bxx;
        for (int i = 0; i < 8; i++) begin stb_cyc[i] = -1; dig[i] = 4'hx; end
        for (int c = 0; c <= ncyc; c++) begin
            if (c > 0) begin
                tick();
                if (w_sol) begin req_cnt++; req_last = c; if (req_cnt == 1) res_at_req = w_res; end
                if (w_stb) begin
                    if (stb_cnt < 8) begin stb_cyc[stb_cnt] = c; dig[stb_cnt] = w_dig; end
                    stb_cnt++;
                end
                if (w_done) begin done_cnt++; done_cyc = c; res_done = w_res; end
                if (!w_busy && busy_low < 0) busy_low = c;
                if ((int'(w_sol) + int'(w_stb) + int'(w_done)) > 1) overlap = 1'b1;
                if (c == r1 + 1)
                    zero_after_rst = !w_sol && !w_stb && !w_busy && !w_done && (w_res == 2'b00) && (w_dig == 4'h0);
                res_end = w_res;
            end
            start = (c == 0) || (c == s1) || (c == s2);
            if (c == 0) pin = p;
            else if (c == s1 || c == s2) pin = p2;
            acc = (c == a1) || (c == a2);
            den = (c == d1);
            rst = (c == r1);
        end
        start = 1'b0; acc = 1'b0; den = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; pin = 16'hFFFF; acc = 1'b1; den = 1'b0;
        tick(); tick(); tick();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            checks++; if (w_sol !== 1'b0)    begin errors++; $display("FAIL rst_sol dut%0d: got %b want 0", s, w_sol); end
            checks++; if (w_stb !== 1'b0)    begin errors++; $display("FAIL rst_stb dut%0d: got %b want 0", s, w_stb); end
            checks++; if (w_busy !== 1'b0)   begin errors++; $display("FAIL rst_busy dut%0d: got %b want 0", s, w_busy); end
            checks++; if (w_done !== 1'b0)   begin errors++; $display("FAIL rst_done dut%0d: got %b want 0", s, w_done); end
            checks++; if (w_res !== 2'b00)   begin errors++; $display("FAIL rst_result dut%0d: got %b want 00", s, w_res); end
            checks++; if (w_dig !== 4'h0)    begin errors++; $display("FAIL rst_digito dut%0d: got %h want 0", s, w_dig); end
        end
        sel = 1'b0; start = 1'b0; acc = 1'b0; rst = 1'b0;
        tick(); tick();
        checks++; if (w_busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy: got %b want 0", w_busy); end
    endtask

    task automatic test_accept;
        int       ec [4] = '{2, 5, 8, 11};
        logic [3:0] ed [4] = '{4'h6, 4'h9, 4'h6, 4'h9};
        xfer(16'h6969, 16'h0, -1, -1, 14, -1, -1, -1, 20);
        checks++; if (req_cnt !== 1)  begin errors++; $display("FAIL s1_req_cnt: got %0d want 1", req_cnt); end
        checks++; if (req_last !== 1) begin errors++; $display("FAIL s1_req_cyc: got %0d want 1", req_last); end
        checks++; if (stb_cnt !== 4)  begin errors++; $display("FAIL s1_stb_cnt: got %0d want 4", stb_cnt); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (stb_cyc[k] !== ec[k]) begin errors++; $display("FAIL s1_stb_cyc%0d: got %0d want %0d", k, stb_cyc[k], ec[k]); end
            checks++; if (dig[k] !== ed[k])     begin errors++; $display("FAIL s1_digit%0d: got %h want %h", k, dig[k], ed[k]); end
        end
        checks++; if (done_cnt !== 1)     begin errors++; $display("FAIL s1_done_cnt: got %0d want 1", done_cnt); end
        checks++; if (done_cyc !== 15)    begin errors++; $display("FAIL s1_done_cyc: got %0d want 15", done_cyc); end
        checks++; if (res_done !== 2'b01) begin errors++; $display("FAIL s1_result: got %b want 01", res_done); end
        checks++; if (busy_low !== 16)    begin errors++; $display("FAIL s1_busy_low: got %0d want 16", busy_low); end
        checks++; if (res_end !== 2'b01)  begin errors++; $display("FAIL s1_result_held: got %b want 01", res_end); end
        checks++; if (overlap !== 1'b0)   begin errors++; $display("FAIL s1_overlap: got %b want 0", overlap); end
    endtask

    task automatic test_deny;
        logic [3:0] ed [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
        xfer(16'h1234, 16'h0, -1, -1, -1, -1, 12, -1, 18);
        for (int k = 0; k < 4; k++) begin
            checks++; if (dig[k] !== ed[k]) begin errors++; $display("FAIL s2_digit%0d: got %h want %h", k, dig[k], ed[k]); end
        end
        checks++; if (done_cyc !== 13)    begin errors++; $display("FAIL s2_done_cyc: got %0d want 13", done_cyc); end
        checks++; if (res_done !== 2'b10) begin errors++; $display("FAIL s2_result: got %b want 10", res_done); end
    endtask

    task automatic test_both_verdicts;
        xfer(16'h1234, 16'h0, -1, -1, 12, -1, 12, -1, 18);
        checks++; if (res_at_req !== 2'b00) begin errors++; $display("FAIL both_result_clear: got %b want 00", res_at_req); end
        checks++; if (done_cyc !== 13)      begin errors++; $display("FAIL both_done_cyc: got %0d want 13", done_cyc); end
        checks++; if (res_done !== 2'b10)   begin errors++; $display("FAIL both_result: got %b want 10", res_done); end
    endtask

    task automatic test_timeout;
        xfer(16'h6969, 16'h0, -1, -1, -1, -1, -1, -1, 32);
        checks++; if (done_cnt !== 1)     begin errors++; $display("FAIL tmo_done_cnt: got %0d want 1", done_cnt); end
        checks++; if (done_cyc !== 28)    begin errors++; $display("FAIL tmo_done_cyc: got %0d want 28", done_cyc); end
        checks++; if (res_done !== 2'b11) begin errors++; $display("FAIL tmo_result: got %b want 11", res_done); end
        checks++; if (busy_low !== 29)    begin errors++; $display("FAIL tmo_busy_low: got %0d want 29", busy_low); end
    endtask

    task automatic test_ignore_while_busy;
        logic [3:0] ed [4] = '{4'h6, 4'h9, 4'h6, 4'h9};
        xfer(16'h6969, 16'hFFFF, 4, 9, 6, 14, -1, -1, 20);
        checks++; if (req_cnt !== 1) begin errors++; $display("FAIL ign_req_cnt: got %0d want 1", req_cnt); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (dig[k] !== ed[k]) begin errors++; $display("FAIL ign_digit%0d: got %h want %h", k, dig[k], ed[k]); end
        end
        checks++; if (done_cnt !== 1)     begin errors++; $display("FAIL ign_done_cnt: got %0d want 1", done_cnt); end
        checks++; if (done_cyc !== 15)    begin errors++; $display("FAIL ign_done_cyc: got %0d want 15", done_cyc); end
        checks++; if (res_done !== 2'b01) begin errors++; $display("FAIL ign_result: got %b want 01", res_done); end
    endtask

    task automatic test_reset_mid;
        xfer(16'h6969, 16'h0, -1, -1, -1, -1, -1, 6, 20);
        checks++; if (zero_after_rst !== 1'b1) begin errors++; $display("FAIL mid_rst_zero: got %b want 1", zero_after_rst); end
        checks++; if (stb_cnt !== 2)  begin errors++; $display("FAIL mid_rst_stb_cnt: got %0d want 2", stb_cnt); end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL mid_rst_done_cnt: got %0d want 0", done_cnt); end
        checks++; if (busy_low !== 7) begin errors++; $display("FAIL mid_rst_busy_low: got %0d want 7", busy_low); end
        xfer(16'h6969, 16'h0, -1, -1, 14, -1, -1, -1, 20);
        checks++; if (stb_cyc[3] !== 11)  begin errors++; $display("FAIL mid_rerun_stb3: got %0d want 11", stb_cyc[3]); end
        checks++; if (done_cyc !== 15)    begin errors++; $display("FAIL mid_rerun_done: got %0d want 15", done_cyc); end
        checks++; if (res_done !== 2'b01) begin errors++; $display("FAIL mid_rerun_result: got %b want 01", res_done); end
    endtask

    task automatic test_back_to_back;
        xfer(16'h6969, 16'h1234, 16, -1, 14, -1, -1, -1, 20);
        checks++; if (req_cnt !== 2)    begin errors++; $display("FAIL b2b_req_cnt: got %0d want 2", req_cnt); end
        checks++; if (req_last !== 17)  begin errors++; $display("FAIL b2b_req_cyc: got %0d want 17", req_last); end
        checks++; if (stb_cyc[4] !== 18) begin errors++; $display("FAIL b2b_stb_cyc: got %0d want 18", stb_cyc[4]); end
        checks++; if (dig[4] !== 4'h1)  begin errors++; $display("FAIL b2b_digit: got %h want 1", dig[4]); end
    endtask

    task automatic test_gap0;
        logic [3:0] ed [4] = '{4'hA, 4'h5, 4'hC, 4'h3};
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        sel = 1'b1;
        xfer(16'hA5C3, 16'h0, -1, -1, 6, -1, -1, -1, 12);
        for (int k = 0; k < 4; k++) begin
            checks++; if (stb_cyc[k] !== 2 + k) begin errors++; $display("FAIL g0_stb_cyc%0d: got %0d want %0d", k, stb_cyc[k], 2 + k); end
            checks++; if (dig[k] !== ed[k])     begin errors++; $display("FAIL g0_digit%0d: got %h want %h", k, dig[k], ed[k]); end
        end
        checks++; if (done_cyc !== 7)     begin errors++; $display("FAIL g0_done_cyc: got %0d want 7", done_cyc); end
        checks++; if (res_done !== 2'b01) begin errors++; $display("FAIL g0_result: got %b want 01", res_done); end
        checks++; if (overlap !== 1'b0)   begin errors++; $display("FAIL g0_overlap: got %b want 0", overlap); end
        sel = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0; rst = 1'b1; start = 1'b0; pin = 16'h0; acc = 1'b0; den = 1'b0;
        test_reset();
        test_accept();
        test_deny();
        test_both_verdicts();
        test_timeout();
        test_ignore_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_gap0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pin_entry_transmitter.md
Name: pin_entry_transmitter

Overview:
Keypad-side sender for the PIN access-control link. On a START pulse it latches a 16-bit PIN and raises a one-cycle access request. It then sends the PIN as four 4-bit digits, most-significant nibble first, each qualified by a one-cycle strobe. It then waits for the controller's accepted/denied verdict, or a timeout, and reports the outcome to the local host.

Parameters:
GAP_CYCLES, 2, idle cycles inserted between consecutive digit strobes (0 allowed = back-to-back strobes)
TIMEOUT, 16, maximum cycles spent waiting for a verdict after the last digit (must be >= 1)

Ports:
CLK  input  1  clock, all logic on rising edge
RESET  input  1  synchronous, active-high reset
START  input  1  host request to transmit; sampled only in IDLE
PIN  input  16  PIN to send; digit order PIN[15:12], [11:8], [7:4], [3:0]; latched when START is accepted
ACCESO_ACEPTADO  input  1  verdict from controller: access granted
ACCESO_DENEGADO  input  1  verdict from controller: access denied
SOLICITUD_ACCESO  output  1  one-cycle access request pulse to controller
DIGITO  output  4  current digit, valid while DIGITO_STB=1, held until next digit
DIGITO_STB  output  1  one-cycle digit-valid strobe
BUSY  output  1  high from the cycle after START acceptance through the REPORT cycle
DONE  output  1  one-cycle completion pulse
RESULT  output  2  00 none, 01 accepted, 10 denied, 11 timeout; held from DONE until next accepted START

Behaviour:
- Reset is synchronous and active-high on CLK.
- While RESET=1, on each edge: state=IDLE, all outputs=0 (RESULT=00), digit index, gap counter and timeout counter=0.
- Reset mid-operation aborts the transfer immediately. No further strobes are sent, and no DONE is issued for the aborted transfer.
- All outputs are registered. "Cycle n" means the cycle after the n-th rising edge, where edge 0 samples START=1.
- IDLE: BUSY=0.
  - START=1 latches PIN into a 16-bit shift register and moves to REQUEST.
- REQUEST (cycle 1): SOLICITUD_ACCESO=1 for exactly this cycle; BUSY=1. Next state is SEND, digit index 0.
- SEND: DIGITO = latched nibble for the current index; DIGITO_STB=1 for this cycle only.
  - Index 3 → WAIT_RESP.
  - Otherwise, GAP_CYCLES=0 → SEND with index+1.
  - Otherwise → GAP.
- GAP: DIGITO_STB=0 and DIGITO holds its value. Stays exactly GAP_CYCLES cycles, then SEND with index+1.
- Strobe cycles are 2 + k*(GAP_CYCLES+1) for k=0..3. With the default, strobes fall in cycles 2, 5, 8, 11.
- WAIT_RESP: the timeout counter starts at 0 on entry and increments every cycle. The verdict inputs are sampled every cycle.
  - ACCESO_DENEGADO=1 → RESULT=10. This takes priority if both verdict inputs are high (fail-safe).
  - Else ACCESO_ACEPTADO=1 → RESULT=01.
  - Else, once the counter reaches TIMEOUT-1 with no verdict → RESULT=11.
  - Any of these outcomes → REPORT on the next cycle.
- REPORT: DONE=1 for one cycle; RESULT is already valid in this cycle. BUSY=1 here and drops when the state returns to IDLE on the next cycle.
- Verdict inputs outside WAIT_RESP are ignored. This includes early or stale pulses during REQUEST, SEND or GAP.
- START while BUSY=1 is ignored, and PIN changes after latching have no effect.
- START in the IDLE cycle right after REPORT is accepted normally (back-to-back transfers).
- When a new START is accepted, RESULT clears to 00 in the REQUEST cycle.
- SOLICITUD_ACCESO, DIGITO_STB and DONE are never high in the same cycle.
- Illegal or unreachable state encodings recover to IDLE with outputs 0.

Test Plan:
1. Defaults; PIN=16'h6969, START pulse in cycle 0; ACCESO_ACEPTADO=1 in cycle 14.
   → SOLICITUD_ACCESO high in cycle 1 only.
   → DIGITO_STB high in cycles 2, 5, 8, 11 with DIGITO=6, 9, 6, 9.
   → DONE in cycle 15, RESULT=01 held.
2. PIN=16'h1234; ACCESO_DENEGADO=1 in cycle 12.
   → digits 1, 2, 3, 4.
   → DONE in cycle 13, RESULT=10.
   → Then both verdicts high together in a second transfer → RESULT=10.
3. No verdict after the last digit (TIMEOUT=16).
   → WAIT_RESP occupies cycles 12–27.
   → DONE in cycle 28, RESULT=11, BUSY low in cycle 29.
4. START pulses in cycles 4 and 9 with PIN changed to 16'hFFFF; ACCESO_ACEPTADO pulsed in cycle 6.
   → all ignored; digits remain 6, 9, 6, 9; no early DONE.
5. RESET asserted in cycle 6 for one cycle.
   → all outputs 0 from cycle 7, no strobes or DONE.
   → A new START then reproduces scenario 1 timing.
6. GAP_CYCLES=0, PIN=16'hA5C3.
   → strobes in consecutive cycles 2–5 with DIGITO=A, 5, C, 3.
   → verdict at cycle 6 gives DONE in cycle 7.
